// File: rtl/mul_error_monitor_pkg.sv
// Shared types for the multiplier error monitor: FSM state encoding and
// default widths used by the top and the S2 error stage.
package mul_error_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH  = 32;

  // Monitor is busy while samples are being taken or flushed through the pipe.
  function automatic logic mon_is_busy(input mon_state_e st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/mul_error_monitor_abs_err.sv
// S2 stage: exact unsigned product of the registered operands and the
// magnitude of its difference from the product under test.
module mul_abs_err
  import mul_error_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [2*DATA_WIDTH-1:0]   prod,
  output logic                      err_valid,
  output logic                      err_mismatch,
  output logic [2*DATA_WIDTH-1:0]   abs_err
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] exact_s;
  logic [PW:0]   diff_s;
  logic [PW-1:0] abs_s;
  logic          valid_r;
  logic          mismatch_r;
  logic [PW-1:0] abs_err_r;

  // Exact product and magnitude of the one-bit-wider difference.
  always_comb begin
    exact_s = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    diff_s  = {1'b0, exact_s} - {1'b0, prod};
    if (diff_s[PW]) begin
      abs_s = (~diff_s[PW-1:0]) + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      abs_s = diff_s[PW-1:0];
    end
  end

  // Stage registers; data only moves with a valid sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r    <= 1'b0;
      mismatch_r <= 1'b0;
      abs_err_r  <= {PW{1'b0}};
    end else begin
      valid_r <= valid;
      if (valid) begin
        mismatch_r <= (exact_s != prod);
        abs_err_r  <= abs_s;
      end
    end
  end

  assign err_valid    = valid_r;
  assign err_mismatch = mismatch_r;
  assign abs_err      = abs_err_r;

endmodule

// File: rtl/mul_error_monitor.sv
// Consumer end of the multiplier test path: accepts operand/product samples,
// checks them against the exact product and accumulates error statistics.
module mul_error_monitor
  import mul_error_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [2*DATA_WIDTH-1:0] in_prod,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    sample_cnt,
  output logic [CNT_WIDTH-1:0]    mismatch_cnt,
  output logic [ACC_WIDTH-1:0]    err_sum,
  output logic [2*DATA_WIDTH-1:0] err_max
);

  localparam int PW = 2 * DATA_WIDTH;

  mon_state_e           state_r, state_s;
  logic [CNT_WIDTH-1:0] num_r, num_s;
  logic [CNT_WIDTH-1:0] acc_cnt_r, acc_cnt_s;
  logic                 in_ready_r, ready_s;
  logic                 busy_r, done_r;
  logic                 clear_s;
  logic                 accept_s;

  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_a_r, s1_b_r;
  logic [PW-1:0]         s1_prod_r;

  logic          s2_valid_s;
  logic          s2_mismatch_s;
  logic [PW-1:0] s2_abs_err_s;

  logic [CNT_WIDTH-1:0] sample_cnt_r, mismatch_cnt_r;
  logic [ACC_WIDTH-1:0] err_sum_r;
  logic [PW-1:0]        err_max_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Error magnitudes are zero-extended; a carry out pins the sum at all-ones.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] s,
                                                   input logic [PW-1:0]        e);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, s} + {{(ACC_WIDTH+1-PW){1'b0}}, e};
    if (sum[ACC_WIDTH]) begin
      return {ACC_WIDTH{1'b1}};
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
  endfunction

  assign accept_s = in_valid && in_ready_r;

  // Run control: start handling, accepted-sample count and drain detection.
  always_comb begin
    state_s   = state_r;
    num_s     = num_r;
    acc_cnt_s = acc_cnt_r;
    ready_s   = in_ready_r;
    clear_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_s   = 1'b1;
          num_s     = num_samples;
          acc_cnt_s = {CNT_WIDTH{1'b0}};
          if (num_samples == {CNT_WIDTH{1'b0}}) begin
            state_s = ST_DRAIN;
            ready_s = 1'b0;
          end else begin
            state_s = ST_RUN;
            ready_s = 1'b1;
          end
        end else begin
          ready_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          acc_cnt_s = acc_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (acc_cnt_s == num_r) begin
            state_s = ST_DRAIN;
            ready_s = 1'b0;
          end else begin
            ready_s = 1'b1;
          end
        end else begin
          ready_s = in_ready_r;
        end
      end
      ST_DRAIN: begin
        ready_s = 1'b0;
        if (!s1_valid_r && !s2_valid_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b0;
      end
    endcase
  end

  // Control registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      num_r      <= {CNT_WIDTH{1'b0}};
      acc_cnt_r  <= {CNT_WIDTH{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      num_r      <= num_s;
      acc_cnt_r  <= acc_cnt_s;
      in_ready_r <= ready_s;
      busy_r     <= mon_is_busy(state_s);
      done_r     <= (state_s == ST_DONE);
    end
  end

  // S1: capture the accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {DATA_WIDTH{1'b0}};
      s1_b_r     <= {DATA_WIDTH{1'b0}};
      s1_prod_r  <= {PW{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r    <= in_a;
        s1_b_r    <= in_b;
        s1_prod_r <= in_prod;
      end
    end
  end

  mul_abs_err #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_abs_err (
    .clk          (clk),
    .rst          (rst),
    .valid        (s1_valid_r),
    .a            (s1_a_r),
    .b            (s1_b_r),
    .prod         (s1_prod_r),
    .err_valid    (s2_valid_s),
    .err_mismatch (s2_mismatch_s),
    .abs_err      (s2_abs_err_s)
  );

  // S3: statistics; start never coincides with a sample still in the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_r   <= {CNT_WIDTH{1'b0}};
      mismatch_cnt_r <= {CNT_WIDTH{1'b0}};
      err_sum_r      <= {ACC_WIDTH{1'b0}};
      err_max_r      <= {PW{1'b0}};
    end else if (clear_s) begin
      sample_cnt_r   <= {CNT_WIDTH{1'b0}};
      mismatch_cnt_r <= {CNT_WIDTH{1'b0}};
      err_sum_r      <= {ACC_WIDTH{1'b0}};
      err_max_r      <= {PW{1'b0}};
    end else if (s2_valid_s) begin
      sample_cnt_r <= sat_inc(sample_cnt_r);
      if (s2_mismatch_s) begin
        mismatch_cnt_r <= sat_inc(mismatch_cnt_r);
      end
      err_sum_r <= sat_add(err_sum_r, s2_abs_err_s);
      if (s2_abs_err_s > err_max_r) begin
        err_max_r <= s2_abs_err_s;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign sample_cnt   = sample_cnt_r;
  assign mismatch_cnt = mismatch_cnt_r;
  assign err_sum      = err_sum_r;
  assign err_max      = err_max_r;

endmodule

// File: tb/tb_mul_error_monitor.sv
// Randomised and directed bench for mul_error_monitor: two builds (32-bit and
// 16-bit accumulator) share stimulus and are checked against a run-level model.
module tb_mul_error_monitor;

  logic        clk, rst, start, in_valid;
  logic [15:0] num_samples;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_prod;

  logic        in_ready, busy, done;
  logic [15:0] sample_cnt, mismatch_cnt, err_max;
  logic [31:0] err_sum;
  logic        in_ready_n, busy_n, done_n;
  logic [15:0] sample_cnt_n, mismatch_cnt_n, err_max_n, err_sum_n;

  int checks = 0;
  int failures = 0;

  mul_error_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_prod(in_prod), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .mismatch_cnt(mismatch_cnt), .err_sum(err_sum), .err_max(err_max)
  );

  mul_error_monitor #(.ACC_WIDTH(16)) dut_n (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_a(in_a), .in_b(in_b),
    .in_prod(in_prod), .busy(busy_n), .done(done_n), .sample_cnt(sample_cnt_n),
    .mismatch_cnt(mismatch_cnt_n), .err_sum(err_sum_n), .err_max(err_max_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Run-level model: which samples get in, when the run finishes, what the stats are.
  typedef struct { longint due; longint err; } pend_t;
  pend_t  m_q[$];
  bit     m_busy, m_done, m_ready;
  int     m_remaining;
  longint m_done_edge, edge_idx;
  longint m_sc, m_mc, m_sum32, m_sum16, m_max;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", nm, act, exp, edge_idx);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_done = 0; m_ready = 0; m_remaining = 0;
    m_done_edge = -1;
    m_sc = 0; m_mc = 0; m_sum32 = 0; m_sum16 = 0; m_max = 0;
  endtask

  task automatic model_apply(input longint e);
    if (m_sc < 65535) m_sc++;
    if (e != 0 && m_mc < 65535) m_mc++;
    m_sum32 = (m_sum32 + e > 64'd4294967295) ? 64'd4294967295 : m_sum32 + e;
    m_sum16 = (m_sum16 + e > 65535) ? 65535 : m_sum16 + e;
    if (e > m_max) m_max = e;
  endtask

  task automatic compare();
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("in_ready_n", in_ready_n, m_ready);
    chk("busy_n", busy_n, m_busy);
    chk("done_n", done_n, m_done);
    if (!m_busy) begin
      chk("sample_cnt", sample_cnt, m_sc);
      chk("mismatch_cnt", mismatch_cnt, m_mc);
      chk("err_sum", err_sum, m_sum32);
      chk("err_max", err_max, m_max);
      chk("sample_cnt_n", sample_cnt_n, m_sc);
      chk("mismatch_cnt_n", mismatch_cnt_n, m_mc);
      chk("err_sum_n", err_sum_n, m_sum16);
      chk("err_max_n", err_max_n, m_max);
    end
  endtask

  // One clock: advance the model with the inputs now driven, then check after the edge.
  task automatic tick();
    longint ex, e;
    if (rst) begin
      if (start && !m_busy) begin
        m_q.delete();
        m_sc = 0; m_mc = 0; m_sum32 = 0; m_sum16 = 0; m_max = 0;
        m_remaining = num_samples;
        m_busy = 1; m_done = 0;
        m_ready = (num_samples != 0);
        if (num_samples == 0) m_done_edge = edge_idx + 1;
      end else if (in_valid && m_ready) begin
        ex = longint'(in_a) * longint'(in_b);
        e = (ex > in_prod) ? ex - in_prod : longint'(in_prod) - ex;
        m_q.push_back('{edge_idx + 2, e});
        m_remaining--;
        if (m_remaining == 0) begin
          m_ready = 0;
          m_done_edge = edge_idx + 3;
        end
      end
      while (m_q.size() > 0 && m_q[0].due == edge_idx) begin
        model_apply(m_q[0].err);
        void'(m_q.pop_front());
      end
      if (m_busy && edge_idx == m_done_edge) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    edge_idx++;
    compare();
  endtask

  task automatic set_idle();
    start = 0; in_valid = 0; in_a = 0; in_b = 0; in_prod = 0;
  endtask

  task automatic do_start(input int n);
    start = 1; num_samples = 16'(n);
    tick();
    start = 0;
  endtask

  task automatic drive_sample(input int a, input int b, input int p);
    in_valid = 1; in_a = 8'(a); in_b = 8'(b); in_prod = 16'(p);
    tick();
    set_idle();
  endtask

  task automatic wait_done();
    set_idle();
    for (int k = 0; k < 200 && !(done && m_done); k++) tick();
    chk("wait_done", done, 1);
  endtask

  task automatic chk_stats(input string nm, input longint sc, input longint mc,
                           input longint sum, input longint mx);
    chk({nm, "_sample_cnt"}, sample_cnt, sc);
    chk({nm, "_mismatch_cnt"}, mismatch_cnt, mc);
    chk({nm, "_err_sum"}, err_sum, sum);
    chk({nm, "_err_max"}, err_max, mx);
  endtask

  initial begin
    int n, mode, ex;
    edge_idx = 0;
    model_reset();
    rst = 0; num_samples = 0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_err_sum", err_sum, 0);
    rst = 1;
    tick();

    // Single exact sample: done four edges after start.
    do_start(1);
    drive_sample(11, 12, 132);
    tick(); tick();
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done_at_4", done, 1);
    chk_stats("t1", 1, 0, 0, 0);

    do_start(3);
    drive_sample(11, 12, 128);
    drive_sample(20, 5, 110);
    drive_sample(3, 3, 9);
    wait_done();
    chk_stats("t2", 3, 2, 14, 10);

    do_start(2);
    drive_sample(255, 255, 0);
    drive_sample(255, 255, 65535);
    wait_done();
    chk_stats("t3", 2, 2, 65535, 65025);

    do_start(2);
    drive_sample(255, 255, 0);
    drive_sample(255, 255, 0);
    wait_done();
    chk("t4_sum32", err_sum, 130050);
    chk("t4_sum16_sat", err_sum_n, 65535);

    // in_valid held for 10 cycles against a 4-sample run.
    do_start(4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = 8'(i + 1); in_b = 8'(3); in_prod = 16'(3 * (i + 1) + i);
      tick();
      if (i == 2) chk("t4_ready_before_last", in_ready, 1);
      if (i == 3) chk("t4_ready_after_last", in_ready, 0);
    end
    wait_done();
    chk_stats("t4b", 4, 3, 6, 3);

    // start in RUN ignored, then an empty run.
    do_start(2);
    drive_sample(7, 7, 49);
    start = 1; num_samples = 16'd9;
    tick();
    start = 0;
    chk("t6_start_ignored_busy", busy, 1);
    drive_sample(7, 8, 50);
    wait_done();
    chk_stats("t6", 2, 1, 6, 6);
    do_start(0);
    tick(); tick();
    chk("t6_zero_done", done, 1);
    chk_stats("t6z", 0, 0, 0, 0);

    // Reset two cycles into a long run.
    do_start(100);
    drive_sample(200, 200, 1);
    drive_sample(100, 3, 2);
    rst = 0;
    #1;
    model_reset();
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 0);
    chk("t5_done", done, 0);
    chk("t5_sc", sample_cnt, 0);
    chk("t5_sum", err_sum, 0);
    tick(); tick();
    rst = 1;
    tick();
    do_start(3);
    drive_sample(2, 3, 7);
    drive_sample(4, 4, 16);
    drive_sample(9, 9, 80);
    wait_done();
    chk_stats("t5_rerun", 3, 2, 2, 1);

    // Random runs with gaps in in_valid and stray start pulses.
    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
      do_start(n);
      for (int k = 0; k < 400 && !m_done; k++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 19) == 0);
        num_samples = 16'($urandom_range(0, 50));
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        ex = int'(in_a) * int'(in_b);
        mode = $urandom_range(0, 2);
        if (mode == 0) in_prod = 16'(ex);
        else if (mode == 1) in_prod = 16'(ex + $urandom_range(0, 40) - 20);
        else in_prod = 16'($urandom);
        tick();
      end
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    // Exact sweep through 10000 samples.
    do_start(10000);
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1;
      in_a = 8'((11 + i) % 256);
      in_b = 8'((12 + i) % 256);
      in_prod = 16'(int'(in_a) * int'(in_b));
      tick();
    end
    wait_done();
    chk_stats("sweep", 10000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
